mem_port_arbiter: RTL

Shares one single-ported memory/bus port between the CPU's instruction-fetch and data-access interfaces using the req/gnt/rvalid handshake of the SoC memory interface. Sits between the processor core and the SoC, so that a single-port memory or slave serves both streams. Data accesses have priority. A streak counter guarantees instruction fetch forward progress, and an ID FIFO routes in-order responses back to the originating requester.

---
 rtl/mem_port_arbiter_pkg.sv | 23 ++
 rtl/mem_port_arbiter_id_fifo.sv | 62 ++++++
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the instruction/data memory port arbiter.
// Source IDs travel through the response FIFO as a single bit.
package mem_arb_pkg;

   typedef enum logic {
      SRC_INSTR = 1'b0,
      SRC_DATA  = 1'b1
   } src_t;

   localparam logic [3:0] BE_ALL = 4'b1111;

   // Index width for a storage of n entries, never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      int unsigned w;
      w = $clog2(n);
      if (w < 32'd1) begin
         idx_width = 32'd1;
      end else begin
         idx_width = w;
      end
   endfunction

endpackage

// File: rtl/mem_port_arbiter_id_fifo.sv
// In-order ID FIFO remembering which requester owns each outstanding transaction.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module arb_id_fifo
   import mem_arb_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             res,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = int'(idx_width(DEPTH));
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;
   logic [WIDTH-1:0] store_r [DEPTH];
   logic             push_en_s;
   logic             pop_en_s;

   // Advance a pointer, toggling the wrap bit when the last slot is passed.
   function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
      if (p[AW-1:0] == LAST_IDX) begin
         ptr_inc = {~p[AW], {AW{1'b0}}};
      end else begin
         ptr_inc = p + (AW+1)'(1);
      end
   endfunction

   assign full      = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
   assign empty     = (wr_ptr_r == rd_ptr_r);
   assign head      = store_r[rd_ptr_r[AW-1:0]];
   assign push_en_s = push & ~full;
   assign pop_en_s  = pop & ~empty;

   // Pointer and storage update; push and pop may coincide.
   always_ff @(posedge clk) begin
      if (res) begin
         wr_ptr_r <= {(AW+1){1'b0}};
         rd_ptr_r <= {(AW+1){1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            store_r[i] <= {WIDTH{1'b0}};
         end
      end else begin
         if (push_en_s) begin
            store_r[wr_ptr_r[AW-1:0]] <= push_data;
            wr_ptr_r                  <= ptr_inc(wr_ptr_r);
         end
         if (pop_en_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Data has priority; a streak counter forces a fetch after DATA_STREAK_MAX data grants.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 2,
   parameter int DATA_STREAK_MAX = 4
) (
   input  logic        clk,
   input  logic        res,
   input  logic        instr_req,
   input  logic [31:0] instr_adr,
   output logic        instr_gnt,
   output logic        instr_r_valid,
   output logic [31:0] instr_read,
   input  logic        data_req,
   input  logic [31:0] data_adr,
   input  logic        data_write_enable,
   input  logic [3:0]  data_be,
   input  logic [31:0] data_write,
   output logic        data_gnt,
   output logic        data_r_valid,
   output logic [31:0] data_read,
   output logic        mem_req,
   output logic [31:0] mem_adr,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        err_rvalid
);

   localparam int SW = int'(idx_width(DATA_STREAK_MAX + 1));
   localparam logic [SW-1:0] STREAK_MAX = SW'(DATA_STREAK_MAX);

   src_t          sel_s;
   src_t          sel_lock_r;
   logic          lock_r;
   logic [SW-1:0] streak_r;
   logic          err_r;
   logic          req_sel_s;
   logic          fifo_full_s;
   logic          fifo_empty_s;
   logic [0:0]    fifo_head_s;
   src_t          head_s;
   logic          push_s;
   logic          pop_s;

   // Source selection: a stalled request keeps its owner until granted.
   always_comb begin
      sel_s = SRC_INSTR;
      if (lock_r) begin
         sel_s = sel_lock_r;
      end else if (instr_req && data_req) begin
         sel_s = (streak_r == STREAK_MAX) ? SRC_INSTR : SRC_DATA;
      end else if (data_req) begin
         sel_s = SRC_DATA;
      end else begin
         sel_s = SRC_INSTR;
      end
   end

   // Downstream request mux; fetches are always full-word reads.
   always_comb begin
      req_sel_s = 1'b0;
      mem_adr   = 32'h0000_0000;
      mem_we    = 1'b0;
      mem_be    = 4'b0000;
      mem_wdata = 32'h0000_0000;
      case (sel_s)
         SRC_DATA: begin
            req_sel_s = data_req;
            mem_adr   = data_adr;
            mem_we    = data_write_enable;
            mem_be    = data_be;
            mem_wdata = data_write;
         end
         SRC_INSTR: begin
            req_sel_s = instr_req;
            mem_adr   = instr_adr;
            mem_we    = 1'b0;
            mem_be    = BE_ALL;
            mem_wdata = 32'h0000_0000;
         end
         default: begin
            req_sel_s = 1'b0;
            mem_adr   = 32'h0000_0000;
            mem_we    = 1'b0;
            mem_be    = 4'b0000;
            mem_wdata = 32'h0000_0000;
         end
      endcase
      mem_req = req_sel_s & ~fifo_full_s & ~res;
   end

   assign instr_gnt = mem_gnt & mem_req & (sel_s == SRC_INSTR);
   assign data_gnt  = mem_gnt & mem_req & (sel_s == SRC_DATA);

   assign push_s = mem_req & mem_gnt;
   assign pop_s  = mem_rvalid & ~fifo_empty_s;
   assign head_s = src_t'(fifo_head_s);

   // Responses return in order, so the FIFO head names their owner.
   assign instr_r_valid = mem_rvalid & ~fifo_empty_s & (head_s == SRC_INSTR) & ~res;
   assign data_r_valid  = mem_rvalid & ~fifo_empty_s & (head_s == SRC_DATA) & ~res;
   assign instr_read    = mem_rdata;
   assign data_read     = mem_rdata;
   assign err_rvalid    = err_r & ~res;

   arb_id_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (1)
   ) u_id_fifo (
      .clk       (clk),
      .res       (res),
      .push      (push_s),
      .push_data (sel_s),
      .pop       (pop_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .head      (fifo_head_s)
   );

   // Lock, streak counter and sticky orphan-response flag.
   always_ff @(posedge clk) begin
      if (res) begin
         lock_r     <= 1'b0;
         sel_lock_r <= SRC_INSTR;
         streak_r   <= {SW{1'b0}};
         err_r      <= 1'b0;
      end else begin
         if (mem_req && !mem_gnt) begin
            lock_r     <= 1'b1;
            sel_lock_r <= sel_s;
         end else begin
            lock_r     <= 1'b0;
         end
         if (!instr_req || instr_gnt) begin
            streak_r <= {SW{1'b0}};
         end else if (data_gnt && (streak_r != STREAK_MAX)) begin
            streak_r <= streak_r + SW'(1);
         end
         if (mem_rvalid && fifo_empty_s) begin
            err_r <= 1'b1;
         end
      end
   end

endmodule
